fetch_ctrl: RTL and testbench
=============================

# fetch_ctrl

Instruction-fetch sequencer for the simple MIPS core. Owns the program counter, drives the address of the combinational instruction ROM, and buffers fetched {pc, instruction} pairs in a 2-entry queue toward decode with a valid/ready handshake. Accepts branch/jump redirects from execute, flushes stale fetches, and halts cleanly when the PC leaves the populated ROM range.

## Interface
- `RESET_PC`, 32'h0000_0000, PC loaded on reset.
- `IMEM_WORDS`, 64, number of ROM words; the valid byte range is [0, IMEM_WORDS*4).
- `clk`  in  1  single clock; all state changes on its rising edge.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `imem_addr`  out  32  byte address to the instruction ROM; always the current PC, word-aligned.
- `imem_rdata`  in  32  ROM data; combinational from `imem_addr`, valid in the same cycle.
- `redir_valid`  in  1  one-cycle redirect request from branch/jump resolution.
- `redir_pc`  in  32  redirect target byte address; bits [1:0] are ignored.
- `if_valid`  out  1  head of the queue holds an instruction.
- `if_ready`  in  1  decode accepts the head entry this cycle.
- `if_pc`  out  32  PC of the head entry.
- `if_instr`  out  32  instruction of the head entry.
- `halt`  out  1  fetch stopped because the PC is out of range.
- `retired_cnt`  out  32  count of handshakes where `if_valid && if_ready`; wraps modulo 2^32.

## Operation
- States: FETCH, HALT. Reset goes to FETCH.
- In FETCH, when `pc < IMEM_WORDS*4` and a queue slot is available, push {pc, imem_rdata} and set pc to pc+4. A slot is available when the queue is not full, or when it is full and a pop happens in the same cycle.
- In FETCH with `pc >= IMEM_WORDS*4`: no push; next state is HALT. Entries already queued continue to drain normally.
- In HALT: no pushes. `halt` = 1. PC is held.
- Pop happens when `if_valid && if_ready`. `retired_cnt` increments on each pop.
- Redirect has priority over every other event in that cycle:
  - the queue is flushed, including any simultaneous pop or push;
  - pc is set to {redir_pc[31:2], 2'b00};
  - state is set to FETCH (this also leaves HALT);
  - a pop in the same cycle as a redirect is discarded and is not counted.
- PC arithmetic is 32-bit unsigned and wraps at 2^32. Wrapping never occurs in practice because of the range check.
- Queue is 2 entries, FIFO order. Outputs come from the head entry, which is held stable while `if_valid && !if_ready`.

## Timing
- Reset values:
  - pc = `imem_addr` = RESET_PC
  - queue empty, `if_valid` = 0
  - `if_pc` = 0, `if_instr` = 0
  - `halt` = 0, `retired_cnt` = 0
  - state = FETCH
- Fetch-to-valid latency is 1 cycle: the word addressed in cycle N appears at the head in cycle N+1 if the queue was empty.
- Throughput is 1 instruction per cycle while `if_ready` is held at 1.
- Redirect in cycle N: `if_valid` = 0 in N+1, target instruction is valid in N+2. That is 1 bubble cycle.
- With backpressure, the queue fills after 2 pushes. `imem_addr` then holds at the next unfetched address.
- `halt` rises in the cycle after the out-of-range PC is seen in FETCH.
- Deasserting `rst_n` mid-operation immediately clears all state, with no clock required. The first fetch occurs on the first edge after release.

## Structure
- `fetch_pkg` contains:
  - `fetch_state_t` {FETCH, HALT};
  - `fetch_entry_t` {pc[31:0], instr[31:0]};
  - constant `FQ_DEPTH` = 2.
- Sub-module `fetch_fifo`: a 2-entry queue of `fetch_entry_t` with push, pop, flush, full and empty signals. Flush overrides push and pop. Queue state is reset asynchronously.
- `fetch_ctrl` contains the PC register, FSM, redirect priority logic and retire counter.

## Test plan
- Reset release with `if_ready`=1 and the team test program in the ROM → `if_pc`/`if_instr` = 0/0x20080020, then 4/0x20090037, then 8/0x01098024 on consecutive cycles; `retired_cnt`=3.
- `if_ready`=0 for 5 cycles after reset → queue holds pc 0 and pc 4; `imem_addr` stays at 8; head stays at 0/0x20080020. Raise `if_ready` → entries 0, 4, 8 follow back-to-back with no bubble.
- Queue full with a simultaneous pop and `redir_valid`=1 with `redir_pc`=0x3B → next cycle `if_valid`=0 and `retired_cnt` is unchanged; the cycle after, `if_pc`=0x38 and `if_instr`=0x0251A02A.
- Redirect to 0xF8 → fetches 0xF8 and 0xFC, then `halt`=1 and `imem_addr` holds at 0x100. Both entries still drain. Redirect to 0 → `halt`=0 and the pc 0 instruction is valid 2 cycles later.
- Assert `rst_n`=0 mid-stream with the queue holding 2 entries and `retired_cnt`=7 → outputs reach their reset values asynchronously; after release, `if_pc`=0 again.
- Run with `if_ready` toggling every cycle for 20 cycles → no duplicated or skipped PCs; `retired_cnt` equals the number of observed handshakes.

Source files
------------

// File: rtl/fetch_pkg.sv
// Shared types for the instruction-fetch sequencer.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
`timescale 1ns/1ps
package fetch_pkg;

  typedef enum logic {
    FETCH = 1'b0,
    HALT  = 1'b1
  } fetch_state_t;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } fetch_entry_t;

  localparam int FQ_DEPTH = 2;
  localparam int FQ_PTR_W = (FQ_DEPTH > 1) ? $clog2(FQ_DEPTH) : 1;
  localparam int FQ_CNT_W = $clog2(FQ_DEPTH + 1);

  // Circular pointer advance that also works for non-power-of-two depths.
  function automatic logic [FQ_PTR_W-1:0] fq_ptr_inc(input logic [FQ_PTR_W-1:0] ptr);
    logic [FQ_PTR_W-1:0] last;
    logic [FQ_PTR_W-1:0] one;
    last = FQ_PTR_W'(FQ_DEPTH - 1);
    one  = FQ_PTR_W'(1);
    if (ptr == last) begin
      fq_ptr_inc = '0;
    end else begin
      fq_ptr_inc = ptr + one;
    end
  endfunction

endpackage

// File: rtl/fetch_ctrl_if.sv
// Fetch-side bundle: ROM address/data, redirect request and the decode handshake.
// Latency: n/a (wires only).
// Backpressure: if_ready from decode; the ROM and redirect paths cannot stall.
// master = fetch_ctrl, slave = the ROM/execute/decode side.
`timescale 1ns/1ps
interface fetch_ctrl_if;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic        redir_valid;
  logic [31:0] redir_pc;
  logic        if_valid;
  logic        if_ready;
  logic [31:0] if_pc;
  logic [31:0] if_instr;

  modport master (
    output imem_addr,
    input  imem_rdata,
    input  redir_valid,
    input  redir_pc,
    output if_valid,
    input  if_ready,
    output if_pc,
    output if_instr
  );

  modport slave (
    input  imem_addr,
    output imem_rdata,
    output redir_valid,
    output redir_pc,
    input  if_valid,
    output if_ready,
    input  if_pc,
    input  if_instr
  );
endinterface

// File: rtl/fetch_fifo.sv
// FQ_DEPTH-entry FIFO of {pc, instr} pairs between the PC stage and decode.
// Latency: a pushed entry is visible at the head on the next cycle.
// Backpressure: push is honoured only when not full or popping in the same cycle; flush wins.
// Ports: push/push_dat in, pop in, flush in, full/empty out, head_dat out.
`timescale 1ns/1ps
module fetch_fifo
  import fetch_pkg::*;
(
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  fetch_entry_t push_dat,
  input  logic         pop,
  input  logic         flush,
  output logic         full,
  output logic         empty,
  output fetch_entry_t head_dat
);

  localparam logic [FQ_CNT_W-1:0] CNT_ONE  = FQ_CNT_W'(1);
  localparam logic [FQ_CNT_W-1:0] CNT_FULL = FQ_CNT_W'(FQ_DEPTH);

  fetch_entry_t          mem_q [FQ_DEPTH];
  fetch_entry_t          mem_d [FQ_DEPTH];
  logic [FQ_PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic [FQ_PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [FQ_CNT_W-1:0]   cnt_q, cnt_d;
  logic                  pop_ok;
  logic                  push_ok;

  assign full     = (cnt_q == CNT_FULL);
  assign empty    = (cnt_q == '0);
  assign head_dat = mem_q[rd_ptr_q];

  assign pop_ok  = pop && !empty;
  // When full, the slot being vacated by a same-cycle pop is the one wr_ptr
  // points at, so the write lands in it after the read has been taken.
  assign push_ok = push && (!full || pop_ok);

  always_comb begin
    mem_d    = mem_q;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    cnt_d    = cnt_q;
    if (flush) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      cnt_d    = '0;
    end else begin
      if (push_ok) begin
        mem_d[wr_ptr_q] = push_dat;
        wr_ptr_d        = fq_ptr_inc(wr_ptr_q);
      end
      if (pop_ok) begin
        rd_ptr_d = fq_ptr_inc(rd_ptr_q);
      end
      if (push_ok && !pop_ok) begin
        cnt_d = cnt_q + CNT_ONE;
      end else if (pop_ok && !push_ok) begin
        cnt_d = cnt_q - CNT_ONE;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < FQ_DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      mem_q    <= mem_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

endmodule

// File: rtl/fetch_ctrl.sv
// Instruction-fetch sequencer: PC, FETCH/HALT FSM, redirect handling, fetch queue, retire count.
// Latency: 1 cycle ROM address to queue head; redirect costs 1 bubble.
// Backpressure: if_ready low holds the head; PC stalls once the 2-entry queue is full.
// Ports: clk, rst_n; bus (fetch_ctrl_if.master); halt; retired_cnt.
`timescale 1ns/1ps
module fetch_ctrl
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          IMEM_WORDS = 64
) (
  input  logic              clk,
  input  logic              rst_n,
  fetch_ctrl_if.master      bus,
  output logic              halt,
  output logic [31:0]       retired_cnt
);

  localparam logic [31:0] IMEM_BYTES = 32'(IMEM_WORDS * 4);
  localparam logic [31:0] PC_RESET   = {RESET_PC[31:2], 2'b00};

  fetch_state_t state_q, state_d;
  logic [31:0]  pc_q, pc_d;
  logic [31:0]  cnt_q, cnt_d;

  logic         fq_full;
  logic         fq_empty;
  logic         fq_push;
  logic         fq_pop;
  logic         hs;
  logic         in_range;
  fetch_entry_t fq_head;
  fetch_entry_t fq_in;

  assign bus.imem_addr = pc_q;
  assign bus.if_valid  = !fq_empty;
  assign bus.if_pc     = fq_head.pc;
  assign bus.if_instr  = fq_head.instr;
  assign halt          = (state_q == HALT);
  assign retired_cnt   = cnt_q;

  assign in_range = (pc_q < IMEM_BYTES);
  assign hs       = bus.if_valid && bus.if_ready;

  // A redirect kills everything in flight this cycle: the queue is flushed,
  // so neither the pop nor a new push may take effect or be counted.
  assign fq_pop  = hs && !bus.redir_valid;
  assign fq_push = (state_q == FETCH) && in_range && (!fq_full || hs)
                   && !bus.redir_valid;

  assign fq_in.pc    = pc_q;
  assign fq_in.instr = bus.imem_rdata;

  fetch_fifo u_fifo (
    .clk      (clk),
    .rst_n    (rst_n),
    .push     (fq_push),
    .push_dat (fq_in),
    .pop      (fq_pop),
    .flush    (bus.redir_valid),
    .full     (fq_full),
    .empty    (fq_empty),
    .head_dat (fq_head)
  );

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    cnt_d   = cnt_q;
    if (bus.redir_valid) begin
      state_d = FETCH;
      pc_d    = bus.redir_pc & 32'hFFFF_FFFC;
    end else begin
      if (fq_push) begin
        pc_d = pc_q + 32'd4;
      end
      if ((state_q == FETCH) && !in_range) begin
        state_d = HALT;
      end
      if (fq_pop) begin
        cnt_d = cnt_q + 32'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= FETCH;
      pc_q    <= PC_RESET;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule

// File: tb/tb_fetch_ctrl.sv
// Directed bench for fetch_ctrl: per-cycle vector table plus async-reset and ready-toggle sequences.
// Latency: n/a.
// Backpressure: driven by the vectors through if_ready.
`timescale 1ns/1ps
module tb_fetch_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        halt;
  logic [31:0] retired_cnt;

  fetch_ctrl_if bus ();

  fetch_ctrl #(
    .RESET_PC   (32'h0000_0000),
    .IMEM_WORDS (64)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .bus         (bus),
    .halt        (halt),
    .retired_cnt (retired_cnt)
  );

  always #5 clk = ~clk;

  localparam logic [31:0] W0  = 32'h2008_0020;
  localparam logic [31:0] W1  = 32'h2009_0037;
  localparam logic [31:0] W2  = 32'h0109_8024;
  localparam logic [31:0] W14 = 32'h0251_A02A;

  // Test program: the first words and word 14 are fixed, the rest are tagged fillers.
  function automatic logic [31:0] rom_word(input logic [31:0] addr);
    logic [5:0] idx;
    idx = addr[7:2];
    case (idx)
      6'd0:    rom_word = W0;
      6'd1:    rom_word = W1;
      6'd2:    rom_word = W2;
      6'd14:   rom_word = W14;
      default: rom_word = {16'hC0DE, 10'd0, idx};
    endcase
  endfunction

  assign bus.imem_rdata = rom_word(bus.imem_addr);

  typedef struct {
    bit          pre_reset;
    bit          rdy;
    bit          rv;
    logic [31:0] rpc;
    bit          ev;
    bit          chk_dat;
    logic [31:0] epc;
    logic [31:0] einstr;
    logic [31:0] eaddr;
    bit          ehalt;
    logic [31:0] ecnt;
  } vec_t;

  vec_t vecs[$];
  int   errors = 0;
  int   checks = 0;

  task automatic add(input bit pre, input bit rdy, input bit rv, input logic [31:0] rpc,
                     input bit ev, input bit cd, input logic [31:0] epc,
                     input logic [31:0] ei, input logic [31:0] ea, input bit eh,
                     input logic [31:0] en);
    vec_t v;
    v.pre_reset = pre; v.rdy = rdy; v.rv = rv; v.rpc = rpc;
    v.ev = ev; v.chk_dat = cd; v.epc = epc; v.einstr = ei;
    v.eaddr = ea; v.ehalt = eh; v.ecnt = en;
    vecs.push_back(v);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    bus.if_ready    = 1'b0;
    bus.redir_valid = 1'b0;
    bus.redir_pc    = 32'h0;
    rst_n = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] exp_pc;
    int          hs;

    rst_n           = 1'b0;
    bus.if_ready    = 1'b0;
    bus.redir_valid = 1'b0;
    bus.redir_pc    = 32'h0;

    // pre, rdy, rv, rpc,  ev, cd, epc, instr, addr, halt, cnt
    // Streaming from reset with decode always ready.
    add(1, 1, 0, 0,        0, 1, 0,        0,                 0,        0, 0);
    add(0, 1, 0, 0,        1, 1, 0,        W0,                4,        0, 0);
    add(0, 1, 0, 0,        1, 1, 4,        W1,                8,        0, 1);
    add(0, 1, 0, 0,        1, 1, 8,        W2,                12,       0, 2);
    add(0, 1, 0, 0,        1, 1, 12,       rom_word(12),      16,       0, 3);
    // Backpressure for 5 cycles, then release.
    add(1, 0, 0, 0,        0, 1, 0,        0,                 0,        0, 0);
    add(0, 0, 0, 0,        1, 1, 0,        W0,                4,        0, 0);
    add(0, 0, 0, 0,        1, 1, 0,        W0,                8,        0, 0);
    add(0, 0, 0, 0,        1, 1, 0,        W0,                8,        0, 0);
    add(0, 0, 0, 0,        1, 1, 0,        W0,                8,        0, 0);
    add(0, 1, 0, 0,        1, 1, 0,        W0,                8,        0, 0);
    add(0, 1, 0, 0,        1, 1, 4,        W1,                12,       0, 1);
    add(0, 1, 0, 0,        1, 1, 8,        W2,                16,       0, 2);
    // Full queue + pop + redirect to an unaligned target.
    add(0, 1, 1, 32'h3B,   1, 1, 12,       rom_word(12),      20,       0, 3);
    add(0, 1, 0, 0,        0, 0, 0,        0,                 32'h38,   0, 3);
    add(0, 1, 0, 0,        1, 1, 32'h38,   W14,               32'h3C,   0, 3);
    // Redirect near the end of the ROM, run into HALT, drain, then redirect out.
    add(0, 0, 1, 32'hF8,   1, 1, 32'h3C,   rom_word(32'h3C),  32'h40,   0, 4);
    add(0, 0, 0, 0,        0, 0, 0,        0,                 32'hF8,   0, 4);
    add(0, 0, 0, 0,        1, 1, 32'hF8,   rom_word(32'hF8),  32'hFC,   0, 4);
    add(0, 0, 0, 0,        1, 1, 32'hF8,   rom_word(32'hF8),  32'h100,  0, 4);
    add(0, 1, 0, 0,        1, 1, 32'hF8,   rom_word(32'hF8),  32'h100,  1, 4);
    add(0, 1, 0, 0,        1, 1, 32'hFC,   rom_word(32'hFC),  32'h100,  1, 5);
    add(0, 1, 1, 32'h0,    0, 0, 0,        0,                 32'h100,  1, 6);
    add(0, 1, 0, 0,        0, 0, 0,        0,                 32'h0,    0, 6);
    add(0, 1, 0, 0,        1, 1, 0,        W0,                4,        0, 6);
    add(0, 1, 0, 0,        1, 1, 4,        W1,                8,        0, 7);

    for (int i = 0; i < vecs.size(); i++) begin
      vec_t v;
      v = vecs[i];
      if (v.pre_reset) do_reset();
      bus.if_ready    = v.rdy;
      bus.redir_valid = v.rv;
      bus.redir_pc    = v.rpc;
      @(negedge clk);
      chk($sformatf("row%0d if_valid", i), 32'(bus.if_valid), 32'(v.ev));
      chk($sformatf("row%0d imem_addr", i), bus.imem_addr, v.eaddr);
      chk($sformatf("row%0d halt", i), 32'(halt), 32'(v.ehalt));
      chk($sformatf("row%0d retired_cnt", i), retired_cnt, v.ecnt);
      if (v.chk_dat) begin
        chk($sformatf("row%0d if_pc", i), bus.if_pc, v.epc);
        chk($sformatf("row%0d if_instr", i), bus.if_instr, v.einstr);
      end
      @(posedge clk); #1;
    end
    bus.redir_valid = 1'b0;

    // Asynchronous reset with two entries queued and seven retired.
    do_reset();
    bus.if_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
    end
    bus.if_ready = 1'b0;
    @(posedge clk); #1;
    @(negedge clk);
    chk("arst pre cnt", retired_cnt, 32'd7);
    chk("arst pre valid", 32'(bus.if_valid), 32'd1);
    chk("arst pre head", bus.if_pc, 32'd28);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst valid", 32'(bus.if_valid), 32'd0);
    chk("arst if_pc", bus.if_pc, 32'd0);
    chk("arst if_instr", bus.if_instr, 32'd0);
    chk("arst imem_addr", bus.imem_addr, 32'd0);
    chk("arst halt", 32'(halt), 32'd0);
    chk("arst cnt", retired_cnt, 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    bus.if_ready = 1'b1;
    @(negedge clk);
    chk("arst rel valid", 32'(bus.if_valid), 32'd0);
    @(posedge clk); #1;
    @(negedge clk);
    chk("arst rel if_pc", bus.if_pc, 32'd0);
    chk("arst rel if_instr", bus.if_instr, W0);

    // if_ready toggling every cycle: PCs must arrive in order with none lost.
    do_reset();
    exp_pc = 32'd0;
    hs     = 0;
    for (int i = 0; i < 20; i++) begin
      bus.if_ready = (i % 2) == 1;
      @(negedge clk);
      if (bus.if_valid && bus.if_ready) begin
        chk($sformatf("toggle hs%0d if_pc", hs), bus.if_pc, exp_pc);
        chk($sformatf("toggle hs%0d if_instr", hs), bus.if_instr, rom_word(exp_pc));
        exp_pc = exp_pc + 32'd4;
        hs++;
      end
      @(posedge clk); #1;
    end
    bus.if_ready = 1'b0;
    @(negedge clk);
    chk("toggle handshakes", 32'(hs), 32'd10);
    chk("toggle retired_cnt", retired_cnt, 32'(hs));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
